fifo_sync_param: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's 32x8 FIFO buffer.
- Generalised data width and power-of-two depth.
- Adds simultaneous read+write in one cycle, programmable almost-full/almost-empty flags, occupancy output, read-valid strobe and overflow/underflow reporting.
- Sits between producer/consumer stages in a single clock domain.

---
 rtl/fifo_sync_param_if.sv | 30 +++
 rtl/fifo_sync_param.sv | 106 ++++++++++
 tb/tb_fifo_sync_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// Handshake/data bundle between a producer/consumer pair and fifo_sync_param.
// The master modport is the user side; the slave modport is the FIFO itself.
interface fifo_sync_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              EN;
    logic              WR;
    logic [DATA_W-1:0] dataIn;
    logic              RD;
    logic [DATA_W-1:0] dataOut;
    logic              dataValid;
    logic              EMPTY;
    logic              FULL;
    logic              ALMOST_EMPTY;
    logic              ALMOST_FULL;
    logic [ADDR_W:0]   COUNT;
    logic              OVF;
    logic              UDF;

    modport master (
        output EN, WR, dataIn, RD,
        input  dataOut, dataValid, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, COUNT, OVF, UDF
    );

    modport slave (
        input  EN, WR, dataIn, RD,
        output dataOut, dataValid, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, COUNT, OVF, UDF
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy flags and error reporting.
// Define FIFO_STICKY_ERR_EN to make OVF/UDF sticky until reset instead of one-cycle pulses.
module fifo_sync_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input logic            Clk,
    input logic            Rst,
    fifo_sync_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              rd_ok, wr_ok;
    logic              wr_rej, rd_rej;

    // Acceptance uses pre-edge occupancy; a full FIFO takes a write only alongside a read.
    always_comb begin
        rd_ok  = bus.EN && bus.RD && (count_q != '0);
        wr_ok  = bus.EN && bus.WR && ((count_q != DEPTH_C) || rd_ok);
        wr_rej = bus.EN && bus.WR && !wr_ok;
        rd_rej = bus.EN && bus.RD && !rd_ok;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = rd_ok;
        mem_d        = mem_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (!Rst) begin
                mem_d[wr_ptr_q] = bus.dataIn;
            end
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            data_out_d = mem_q[rd_ptr_q];
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

`ifdef FIFO_STICKY_ERR_EN
        ovf_d = ovf_q || wr_rej;
        udf_d = udf_q || rd_rej;
`else
        ovf_d = wr_rej;
        udf_d = rd_rej;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    // Storage survives reset; the pointer reset alone makes old contents unreachable.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    assign bus.dataOut      = data_out_q;
    assign bus.dataValid    = data_valid_q;
    assign bus.COUNT        = count_q;
    assign bus.EMPTY        = (count_q == '0);
    assign bus.FULL         = (count_q == DEPTH_C);
    assign bus.ALMOST_EMPTY = (count_q <= AE_C);
    assign bus.ALMOST_FULL  = (count_q >= AF_C);
    assign bus.OVF          = ovf_q;
    assign bus.UDF          = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised and directed bench for fifo_sync_param against a queue-based reference model.
// Works in both the pulse and the FIFO_STICKY_ERR_EN error builds.
module tb_fifo_sync_param;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int AF_LEVEL = 6;
    localparam int AE_LEVEL = 2;

    logic Clk;
    logic Rst;

    fifo_sync_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fifo_sync_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] exp_dout;
    logic              exp_valid;
    logic              exp_ovf;
    logic              exp_udf;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: the FIFO is a plain queue, occupancy is its size.
    task automatic modelStep(input logic rst, input logic en, input logic wr, input logic rd,
                             input logic [DATA_W-1:0] din);
        logic rd_acc, wr_acc;
        if (rst) begin
            model_q.delete();
            exp_dout  = '0;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_udf   = 1'b0;
        end else if (!en) begin
            exp_valid = 1'b0;
`ifndef FIFO_STICKY_ERR_EN
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
`endif
        end else begin
            rd_acc = rd && (model_q.size() != 0);
            wr_acc = wr && ((model_q.size() != DEPTH) || rd_acc);
            if (rd_acc) exp_dout = model_q.pop_front();
            if (wr_acc) model_q.push_back(din);
            exp_valid = rd_acc;
`ifdef FIFO_STICKY_ERR_EN
            exp_ovf = exp_ovf || (wr && !wr_acc);
            exp_udf = exp_udf || (rd && !rd_acc);
`else
            exp_ovf = wr && !wr_acc;
            exp_udf = rd && !rd_acc;
`endif
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic wr, input logic rd,
                                 input logic [DATA_W-1:0] din);
        int n;
        @(negedge Clk);
        Rst        = rst;
        bus.EN     = en;
        bus.WR     = wr;
        bus.RD     = rd;
        bus.dataIn = din;
        @(posedge Clk);
        modelStep(rst, en, wr, rd, din);
        #1;
        n = model_q.size();
        checkOutput("dataOut",      64'(bus.dataOut),      64'(exp_dout));
        checkOutput("dataValid",    64'(bus.dataValid),    64'(exp_valid));
        checkOutput("COUNT",        64'(bus.COUNT),        64'(n));
        checkOutput("EMPTY",        64'(bus.EMPTY),        64'(n == 0));
        checkOutput("FULL",         64'(bus.FULL),         64'(n == DEPTH));
        checkOutput("ALMOST_EMPTY", 64'(bus.ALMOST_EMPTY), 64'(n <= AE_LEVEL));
        checkOutput("ALMOST_FULL",  64'(bus.ALMOST_FULL),  64'(n >= AF_LEVEL));
        checkOutput("OVF",          64'(bus.OVF),          64'(exp_ovf));
        checkOutput("UDF",          64'(bus.UDF),          64'(exp_udf));
    endtask

    initial begin
        logic [DATA_W-1:0] word;
        Rst        = 1'b1;
        bus.EN     = 1'b0;
        bus.WR     = 1'b0;
        bus.RD     = 1'b0;
        bus.dataIn = '0;
        exp_dout   = '0;
        exp_valid  = 1'b0;
        exp_ovf    = 1'b0;
        exp_udf    = 1'b0;

        applyStimulus(1, 0, 0, 0, '0);
        checkOutput("reset_count", 64'(bus.COUNT), 64'd0);

        // Fill with 0x11..0x88, then one write too many.
        for (int i = 1; i <= DEPTH; i++) applyStimulus(0, 1, 1, 0, DATA_W'(32'h11 * i));
        checkOutput("fill_full", 64'(bus.FULL), 64'd1);
        applyStimulus(0, 1, 1, 0, DATA_W'(32'h99));
        checkOutput("ovf_on_full", 64'(bus.OVF), 64'd1);
        applyStimulus(0, 1, 0, 0, '0);

        // Drain in order, then one read too many.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(0, 1, 0, 1, '0);
            checkOutput("drain_order", 64'(bus.dataOut), 64'(32'h11 * i));
        end
        applyStimulus(0, 1, 0, 1, '0);
        checkOutput("udf_hold_dout", 64'(bus.dataOut), 64'h88);

        // Simultaneous read+write while full.
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 1, 0, DATA_W'(32'hC0 + i));
        applyStimulus(0, 1, 1, 1, DATA_W'(32'hAA));
        checkOutput("full_rw_dout", 64'(bus.dataOut), 64'hC0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 1, '0);
        checkOutput("aa_last", 64'(bus.dataOut), 64'hAA);

        // Simultaneous read+write while empty: no bypass.
        applyStimulus(0, 1, 1, 1, DATA_W'(32'h55));
        checkOutput("empty_rw_count", 64'(bus.COUNT), 64'd1);
        applyStimulus(0, 1, 0, 1, '0);
        checkOutput("empty_rw_read", 64'(bus.dataOut), 64'h55);

        // Pointer wrap at steady occupancy 3.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, $urandom);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 1, 1, $urandom);
        checkOutput("wrap_count", 64'(bus.COUNT), 64'd3);

        // Reset mid-stream at occupancy 5, then a frozen cycle.
        applyStimulus(0, 1, 1, 0, $urandom);
        applyStimulus(0, 1, 1, 0, $urandom);
        applyStimulus(1, 1, 1, 1, $urandom);
        checkOutput("mid_rst_dout", 64'(bus.dataOut), 64'd0);
        applyStimulus(0, 1, 1, 0, DATA_W'(32'h77));
        applyStimulus(0, 1, 1, 0, DATA_W'(32'h78));
        applyStimulus(0, 0, 1, 1, $urandom);
        applyStimulus(0, 0, 1, 1, $urandom);
        applyStimulus(0, 1, 0, 1, '0);
        checkOutput("frozen_kept", 64'(bus.dataOut), 64'h77);

        // Random traffic with occasional resets and enable drops.
        for (int i = 0; i < 600; i++) begin
            word = $urandom;
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                          1'($urandom), 1'($urandom), word);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
